// File: rtl/proc_pkg.sv
// proc_pkg: opcodes, state encoding and field helpers shared by the memory stage
package proc_pkg;

    localparam logic [4:0]  OP_LW = 5'b01000;
    localparam logic [4:0]  OP_SW = 5'b00111;
    localparam logic [31:0] NOP   = 32'b0;

    typedef enum logic {IDLE, ACCESS} state_t;

    function automatic logic [4:0] opcode(input logic [31:0] ir);
        return ir[31:27];
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// mem_stage_ctrl_if: req/ack data-memory bus between the memory stage and the data memory
interface mem_stage_ctrl_if #(parameter int ADDR_W = 12);

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_ack, mem_rdata);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_ack, mem_rdata);

endinterface

// File: rtl/mem_stage_ctrl_timeout.sv
// mem_timeout_ctr: saturating 8-bit access-cycle counter flagging the last allowed cycle
module mem_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic hit_o
);

    logic [7:0] count_q, count_d;

    // clear wins; otherwise count up while enabled, never past TIMEOUT
    always_comb begin
        count_d = clr_i ? 8'd0 : (en_i && count_q < 8'(TIMEOUT)) ? count_q + 8'd1 : count_q;
    end

    // count register
    always_ff @(posedge clk) begin
        if (reset) count_q <= 8'd0;
        else       count_q <= count_d;
    end

    assign hit_o = (count_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-stage controller running lw/sw on the data memory and stalling upstream
module mem_stage_ctrl
    import proc_pkg::*;
#(
    parameter int          ADDR_W   = 12,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid_in,
    input  logic [31:0]             ir_in,
    input  logic [31:0]             o_in,
    input  logic [31:0]             b_in,
    mem_stage_ctrl_if.master        mem,
    output logic                    stall,
    output logic                    valid_out,
    output logic [31:0]             ir_out,
    output logic [31:0]             o_out,
    output logic [31:0]             d_out,
    output logic                    err
);

    state_t            state_q, state_d;
    logic [31:0]       ir_q, ir_d, o_q, o_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              valid_out_q, valid_out_d;
    logic [31:0]       ir_out_q, ir_out_d, o_out_q, o_out_d, d_out_q, d_out_d;
    logic              err_q, err_d;
    logic              hit;
    logic              in_is_mem;

    assign in_is_mem = (opcode(ir_in) == OP_LW) || (opcode(ir_in) == OP_SW);

    mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
        .clk   (clk),
        .reset (reset),
        .clr_i (state_q == IDLE),
        .en_i  (state_q == ACCESS),
        .hit_o (hit)
    );

    // next state: accept in IDLE, complete an access on ack or on the last allowed cycle
    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        o_d         = o_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        valid_out_d = 1'b0;
        ir_out_d    = ir_out_q;
        o_out_d     = o_out_q;
        d_out_d     = d_out_q;
        err_d       = err_q;
        if (state_q == IDLE) begin
            if (valid_in && in_is_mem) begin
                state_d     = ACCESS;
                ir_d        = ir_in;
                o_d         = o_in;
                mem_req_d   = 1'b1;
                mem_we_d    = (opcode(ir_in) == OP_SW);
                mem_addr_d  = o_in[ADDR_W-1:0];
                mem_wdata_d = b_in;
            end else if (valid_in) begin
                valid_out_d = 1'b1;
                ir_out_d    = ir_in;
                o_out_d     = o_in;
                d_out_d     = NOP;
            end
        end else if (mem.mem_ack || hit) begin
            state_d     = IDLE;
            mem_req_d   = 1'b0;
            valid_out_d = 1'b1;
            ir_out_d    = ir_q;
            o_out_d     = o_q;
            d_out_d     = (opcode(ir_q) != OP_LW) ? NOP : mem.mem_ack ? mem.mem_rdata : ERR_DATA;
            err_d       = err_q | ~mem.mem_ack;
        end
    end

    // state, capture and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ir_q        <= '0;
            o_q         <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            valid_out_q <= 1'b0;
            ir_out_q    <= '0;
            o_out_q     <= '0;
            d_out_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            o_q         <= o_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            valid_out_q <= valid_out_d;
            ir_out_q    <= ir_out_d;
            o_out_q     <= o_out_d;
            d_out_q     <= d_out_d;
            err_q       <= err_d;
        end
    end

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign stall         = (state_q != IDLE);
    assign valid_out     = valid_out_q;
    assign ir_out        = ir_out_q;
    assign o_out         = o_out_q;
    assign d_out         = d_out_q;
    assign err           = err_q;

endmodule
